// File: rtl/countdown_pkg.sv
// State codes and BCD limits shared by the mm:ss countdown controller.
package countdown_pkg;

    typedef enum logic [2:0] {
        SET_SEC = 3'd1,
        SET_MIN = 3'd2,
        PAUSED  = 3'd3,
        RUN     = 3'd4,
        FLASH   = 3'd5
    } state_e;

    localparam logic [7:0] SEC_MAX   = 8'h59;
    localparam logic [7:0] MIN_MAX   = 8'h99;
    localparam logic [6:0] LED_FLASH = 7'h7F;

endpackage

// File: rtl/countdown_ctrl_key_pulse.sv
// Two-flop synchronizer plus falling-edge detector for one raw active-low key;
// the registered pulse is high two cycles after the edge is first sampled.
module key_pulse (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = prev_q & ~sync2_q;
    end

    // NOTE: flops use non-blocking assignments so each stage samples its pre-edge input.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset to the released level so leaving reset never looks like a press.
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/countdown_ctrl.sv
// Operator entry, 1 Hz mm:ss countdown and expiry flash for the board timer.
// Define COUNTDOWN_BLINK_EN to blink the display while expired; otherwise it stays lit.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int FLASH_DIV = 25_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] sw_val,
    input  logic       key_set_n,
    input  logic       key_run_n,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [2:0] state,
    output logic       blank,
    output logic [9:0] led
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    if (TICK_DIV < 1 || FLASH_DIV < 1) begin : g_bad_divider
        $error("countdown_ctrl: TICK_DIV and FLASH_DIV must be positive");
    end

    state_e        state_q, state_d;
    logic [7:0]    sec_q, sec_d;
    logic [7:0]    min_q, min_d;
    logic          blank_q, blank_d;
    logic [9:0]    led_q, led_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          set_p, run_p;
    logic          tick;
    logic [15:0]   dec_value;

`ifdef COUNTDOWN_BLINK_EN
    localparam int            FW         = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
`endif

    key_pulse u_key_set (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (key_set_n),
        .pulse (set_p)
    );

    key_pulse u_key_run (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (key_run_n),
        .pulse (run_p)
    );

    function automatic logic [7:0] clamp_sec(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] > SEC_MAX[3:0]) r[3:0] = SEC_MAX[3:0];
        if (v[7:4] > SEC_MAX[7:4]) r = SEC_MAX;
        return r;
    endfunction

    function automatic logic [7:0] clamp_min(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] > MIN_MAX[3:0]) r[3:0] = MIN_MAX[3:0];
        if (v[7:4] > MIN_MAX[7:4]) r[7:4] = MIN_MAX[7:4];
        return r;
    endfunction

    // One-second BCD decrement of {mm, ss}; 00:00 is held rather than wrapped.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = v;
        if (v == 16'h0000) return v;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else if (st != 4'd0) begin
            st = st - 4'd1;
            so = 4'd9;
        end else begin
            {st, so} = SEC_MAX;
            if (mo != 4'd0) begin
                mo = mo - 4'd1;
            end else begin
                mt = mt - 4'd1;
                mo = 4'd9;
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign tick      = (tick_cnt_q == TICK_LAST);
    assign dec_value = bcd_dec({min_q, sec_q});

    // NOTE: every always_comb output gets a default first, so no branch can infer a latch.
    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        min_d      = min_q;
        tick_cnt_d = tick_cnt_q;
        blank_d    = 1'b0;
`ifdef COUNTDOWN_BLINK_EN
        flash_cnt_d = '0;
`endif

        case (state_q)
            SET_SEC: begin
                if (set_p) begin
                    sec_d   = clamp_sec(sw_val);
                    state_d = SET_MIN;
                end
            end
            SET_MIN: begin
                if (set_p) begin
                    min_d   = clamp_min(sw_val);
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (run_p) begin
                    if ({min_q, sec_q} == 16'h0000) begin
                        state_d = FLASH;
                    end else begin
                        state_d    = RUN;
                        tick_cnt_d = '0;
                    end
                end else if (set_p) begin
                    state_d = SET_SEC;
                end
            end
            RUN: begin
                // The prescaler freezes on the pausing edge unless that edge is also a tick.
                if (tick) begin
                    tick_cnt_d     = '0;
                    {min_d, sec_d} = dec_value;
                end else if (!run_p) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
                if (tick && dec_value == 16'h0000) begin
                    state_d = FLASH;
                end else if (run_p) begin
                    state_d = PAUSED;
                end
            end
            FLASH: begin
                if (set_p) begin
                    sec_d   = 8'h00;
                    min_d   = 8'h00;
                    state_d = SET_SEC;
                end else begin
`ifdef COUNTDOWN_BLINK_EN
                    if (flash_cnt_q == FLASH_LAST) begin
                        flash_cnt_d = '0;
                        blank_d     = ~blank_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 1'b1;
                        blank_d     = blank_q;
                    end
`else
                    blank_d = 1'b0;
`endif
                end
            end
            default: state_d = SET_SEC;
        endcase

        led_d = {((state_d == FLASH) && !blank_d) ? LED_FLASH : 7'h00, state_d};
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= SET_SEC;
            sec_q      <= 8'h00;
            min_q      <= 8'h00;
            blank_q    <= 1'b0;
            led_q      <= 10'h000;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            blank_q    <= blank_d;
            led_q      <= led_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

`ifdef COUNTDOWN_BLINK_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset) flash_cnt_q <= '0;
        else       flash_cnt_q <= flash_cnt_d;
    end
`endif

    assign sec_bcd = sec_q;
    assign min_bcd = min_q;
    assign state   = state_q;
    assign blank   = blank_q;
    assign led     = led_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with TICK_DIV=8 and FLASH_DIV=4.
module tb_countdown_ctrl;

`ifdef COUNTDOWN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif
    localparam logic [9:0] LED_BLINK = BLINK ? 10'h005 : 10'h3FD;

    logic       clk;
    logic       reset;
    logic [7:0] sw_val;
    logic       key_set_n;
    logic       key_run_n;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [2:0] state;
    logic       blank;
    logic [9:0] led;

    int checks = 0;
    int errors = 0;

    countdown_ctrl #(
        .TICK_DIV  (8),
        .FLASH_DIV (4)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .sw_val    (sw_val),
        .key_set_n (key_set_n),
        .key_run_n (key_run_n),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .state     (state),
        .blank     (blank),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200_000;
        $display("FAIL watchdog: time limit reached before summary, expected completion");
        $fatal(1, "watchdog expired");
    end

    // {state, min, sec, blank, led}
    function automatic logic [29:0] snap();
        return {state, min_bcd, sec_bcd, blank, led};
    endfunction

    function automatic logic [29:0] exp_v(input logic [2:0] st, input logic [7:0] mn,
                                          input logic [7:0] sc, input logic bl, input logic [9:0] ld);
        return {st, mn, sc, bl, ld};
    endfunction

    function automatic string show(input logic [29:0] v);
        return $sformatf("state=%0d %h:%h blank=%b led=%h", v[29:27], v[26:19], v[18:11], v[10], v[9:0]);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Registers update on the 4th edge after the key is driven low.
    task automatic press(input bit use_set);
        if (use_set) key_set_n = 1'b0;
        else         key_run_n = 1'b0;
        step(2);
        key_set_n = 1'b1;
        key_run_n = 1'b1;
        step(2);
    endtask

    task automatic load(input logic [7:0] sec_v, input logic [7:0] min_v);
        sw_val = sec_v;
        press(1'b1);
        sw_val = min_v;
        press(1'b1);
    endtask

    task automatic test_reset();
        logic [29:0] e;
        reset = 1'b1;
        step(2);
        e = exp_v(3'd1, 8'h00, 8'h00, 1'b0, 10'h000);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL reset_hold: got %s, expected %s", show(snap()), show(e)); end
        reset = 1'b0;
        step(1);
        e = exp_v(3'd1, 8'h00, 8'h00, 1'b0, 10'h001);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL reset_release: got %s, expected %s", show(snap()), show(e)); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (snap() !== e) begin errors++; $display("FAIL idle_%0d: got %s, expected %s", i, show(snap()), show(e)); end
        end
    endtask

    task automatic test_entry_clamp();
        logic [29:0] e;
        sw_val    = 8'h7A;
        key_set_n = 1'b0;
        step(2);
        key_set_n = 1'b1;
        step(1);
        e = exp_v(3'd1, 8'h00, 8'h00, 1'b0, 10'h001);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL set_latency_edge2: got %s, expected %s", show(snap()), show(e)); end
        step(1);
        e = exp_v(3'd2, 8'h00, 8'h59, 1'b0, 10'h002);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL sec_clamp: got %s, expected %s", show(snap()), show(e)); end
        sw_val = 8'h3F;
        press(1'b1);
        e = exp_v(3'd3, 8'h39, 8'h59, 1'b0, 10'h003);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL min_clamp: got %s, expected %s", show(snap()), show(e)); end
    endtask

    task automatic test_countdown_borrow();
        logic [29:0] e;
        press(1'b1);
        e = exp_v(3'd1, 8'h39, 8'h59, 1'b0, 10'h001);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL paused_set_holds: got %s, expected %s", show(snap()), show(e)); end
        load(8'h00, 8'h01);
        press(1'b0);
        step(7);
        e = exp_v(3'd4, 8'h01, 8'h00, 1'b0, 10'h004);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL before_first_tick: got %s, expected %s", show(snap()), show(e)); end
        step(1);
        e = exp_v(3'd4, 8'h00, 8'h59, 1'b0, 10'h004);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL minute_borrow: got %s, expected %s", show(snap()), show(e)); end
        step(8 * 9);
        e = exp_v(3'd4, 8'h00, 8'h50, 1'b0, 10'h004);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL ones_count: got %s, expected %s", show(snap()), show(e)); end
        step(8);
        e = exp_v(3'd4, 8'h00, 8'h49, 1'b0, 10'h004);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL tens_borrow: got %s, expected %s", show(snap()), show(e)); end
        step(8 * 48);
        e = exp_v(3'd4, 8'h00, 8'h01, 1'b0, 10'h004);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL last_second: got %s, expected %s", show(snap()), show(e)); end
        step(8);
        e = exp_v(3'd5, 8'h00, 8'h00, 1'b0, 10'h3FD);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL expire_flash: got %s, expected %s", show(snap()), show(e)); end
    endtask

    task automatic test_flash_restart();
        logic [29:0] e;
        step(3);
        e = exp_v(3'd5, 8'h00, 8'h00, 1'b0, 10'h3FD);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL flash_pre_toggle: got %s, expected %s", show(snap()), show(e)); end
        step(1);
        e = exp_v(3'd5, 8'h00, 8'h00, BLINK, LED_BLINK);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL flash_toggle: got %s, expected %s", show(snap()), show(e)); end
        step(4);
        e = exp_v(3'd5, 8'h00, 8'h00, 1'b0, 10'h3FD);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL flash_toggle_back: got %s, expected %s", show(snap()), show(e)); end
        press(1'b0);
        e = exp_v(3'd5, 8'h00, 8'h00, BLINK, LED_BLINK);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL flash_run_ignored: got %s, expected %s", show(snap()), show(e)); end
        press(1'b1);
        e = exp_v(3'd1, 8'h00, 8'h00, 1'b0, 10'h001);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL flash_restart: got %s, expected %s", show(snap()), show(e)); end
    endtask

    task automatic test_pause_resume();
        logic [29:0] e;
        load(8'h30, 8'h02);
        press(1'b0);
        press(1'b0);
        e = exp_v(3'd3, 8'h02, 8'h30, 1'b0, 10'h003);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL pause_at_3: got %s, expected %s", show(snap()), show(e)); end
        step(20);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL pause_frozen: got %s, expected %s", show(snap()), show(e)); end
        press(1'b0);
        step(7);
        e = exp_v(3'd4, 8'h02, 8'h30, 1'b0, 10'h004);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL resume_no_tick: got %s, expected %s", show(snap()), show(e)); end
        step(1);
        e = exp_v(3'd4, 8'h02, 8'h29, 1'b0, 10'h004);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL resume_first_tick: got %s, expected %s", show(snap()), show(e)); end
        step(4);
        press(1'b0);
        e = exp_v(3'd3, 8'h02, 8'h28, 1'b0, 10'h003);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL tick_with_run: got %s, expected %s", show(snap()), show(e)); end
    endtask

    task automatic test_edges();
        logic [29:0] e;
        press(1'b1);
        e = exp_v(3'd1, 8'h02, 8'h28, 1'b0, 10'h001);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL set_from_paused: got %s, expected %s", show(snap()), show(e)); end
        load(8'h00, 8'h00);
        press(1'b0);
        e = exp_v(3'd5, 8'h00, 8'h00, 1'b0, 10'h3FD);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL zero_run_flash: got %s, expected %s", show(snap()), show(e)); end
        press(1'b1);
        load(8'h01, 8'h00);
        press(1'b0);
        step(4);
        press(1'b0);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL last_tick_with_run: got %s, expected %s", show(snap()), show(e)); end
        step(4);
        e = exp_v(3'd5, 8'h00, 8'h00, BLINK, LED_BLINK);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL flash_before_reset: got %s, expected %s", show(snap()), show(e)); end
        reset = 1'b1;
        step(1);
        e = exp_v(3'd1, 8'h00, 8'h00, 1'b0, 10'h000);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL reset_mid_flash: got %s, expected %s", show(snap()), show(e)); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_run();
        logic [29:0] e;
        load(8'h00, 8'h05);
        press(1'b0);
        step(10);
        e = exp_v(3'd4, 8'h04, 8'h59, 1'b0, 10'h004);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL run_before_reset: got %s, expected %s", show(snap()), show(e)); end
        reset = 1'b1;
        step(1);
        e = exp_v(3'd1, 8'h00, 8'h00, 1'b0, 10'h000);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL reset_mid_run: got %s, expected %s", show(snap()), show(e)); end
        reset = 1'b0;
        step(1);
        e = exp_v(3'd1, 8'h00, 8'h00, 1'b0, 10'h001);
        checks++;
        if (snap() !== e) begin errors++; $display("FAIL after_reset_mid_run: got %s, expected %s", show(snap()), show(e)); end
    endtask

    initial begin
        reset     = 1'b1;
        sw_val    = 8'h00;
        key_set_n = 1'b1;
        key_run_n = 1'b1;
        test_reset();
        test_entry_clamp();
        test_countdown_borrow();
        test_flash_restart();
        test_pause_resume();
        test_edges();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the board-level mm:ss countdown timer. It takes the raw push-button and switch inputs, walks the operator through setting seconds and minutes, and runs the 1 Hz countdown. On expiry it drives the flash phase. It owns the timer's value registers and state code; it feeds the 7-segment decoders and LEDR bank at the top level.

## Interface
- TICK_DIV, 50_000_000: CLOCK_50 cycles per countdown second
- FLASH_DIV, 25_000_000: cycles per flash half-period (blank toggle)
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- sw_val  in  8  BCD entry value, {tens, ones}
- key_set_n  in  1  raw active-low SET button (KEY[1])
- key_run_n  in  1  raw active-low START/STOP button (KEY[2])
- sec_bcd  out  8  seconds, BCD 00–59
- min_bcd  out  8  minutes, BCD 00–99
- state  out  3  current state code
- blank  out  1  1 = display digits off
- led  out  10  LEDR drive

## Operation
- Key inputs: each passes a 2-flop synchronizer, then falling-edge detect, giving a one-cycle pulse (set_p, run_p). Debounce is out of scope; inputs are assumed clean.
- States, with codes:
  - SET_SEC=1
  - SET_MIN=2
  - PAUSED=3
  - RUN=4
  - FLASH=5
  - Codes 0, 6 and 7 are illegal and return to SET_SEC next cycle.
- Reset: state=SET_SEC, sec_bcd=00, min_bcd=00, blank=0, led=0, prescalers=0, sync flops=1 (released).
- SET_SEC, on set_p:
  - sec_bcd ← clamp(sw_val), then go to SET_MIN.
  - Clamp rule: a nibble >9 becomes 9; a tens digit >5 gives a result of 59.
- SET_MIN, on set_p:
  - min_bcd ← sw_val, with each nibble >9 becoming 9. Go to PAUSED.
- PAUSED:
  - run_p: if value == 00:00 go to FLASH, else go to RUN and clear the tick prescaler.
  - set_p: go to SET_SEC, values held.
- RUN:
  - The tick prescaler counts 0..TICK_DIV-1. At terminal count it issues a tick and wraps.
  - Tick decrements BCD mm:ss: ones digit borrow; :x0 → :x9 with tens borrow; :00 → :59 with minute borrow.
  - A tick taking the value to 00:00 sends the block to FLASH.
  - run_p goes to PAUSED; the prescaler value is held.
  - set_p is ignored.
- FLASH:
  - The flash prescaler counts 0..FLASH_DIV-1. At terminal count blank toggles.
  - On set_p: sec_bcd=min_bcd=00, blank=0, go to SET_SEC.
  - run_p is ignored.
- Simultaneous events:
  - In PAUSED or RUN, run_p wins over set_p.
  - In RUN, a tick and run_p in the same cycle: the decrement is applied and the state goes to PAUSED. If that decrement reaches 00:00, FLASH wins.
- led:
  - led[2:0]=state.
  - led[9:3]=7'h7F while in FLASH with blank=0, else 0.
- blank is 0 in every state except FLASH.

## Timing
- Key latency:
  - Raw falling edge sampled at clock n.
  - Pulse is high during cycle n+2.
  - State and value registers update at edge n+3.
- All outputs are registered; no combinational path from inputs to outputs.
- First decrement after entering RUN occurs exactly TICK_DIV cycles after the RUN entry edge. Later decrements follow every TICK_DIV cycles.
- Entering FLASH: blank=0 and flash prescaler=0 on the entry edge. First toggle comes FLASH_DIV cycles later.
- Reset asserted mid-RUN or mid-FLASH takes priority over everything on that edge.

## Configuration
- COUNTDOWN_BLINK_EN:
  - Defined: FLASH toggles blank and led[9:3] as described above.
  - Undefined: the flash prescaler is removed; in FLASH, blank is held 0 and led[9:3] is held 7'h7F steady.

## Structure
- Shared package countdown_pkg holds:
  - State enum/localparams (SET_SEC..FLASH, 3-bit).
  - BCD max constants (SEC_MAX=8'h59, MIN_MAX=8'h99).
- Sub-module key_pulse (synchronizer plus falling-edge detector, one instance per key).
- BCD decrement and clamp are functions inside countdown_ctrl.

## Test plan
All cases use TICK_DIV=8 and FLASH_DIV=4.
- Reset then idle: state=1, sec/min=00, blank=0, led=10'h001. Hold set_n/run_n high for 20 cycles and the state stays 1.
- Entry with clamp: sw_val=8'h7A then set_p gives sec=59 and state=2. sw_val=8'h3F then set_p gives min=39 and state=3.
- Countdown borrow: start from 01:00, run_p. After 8 cycles the value is 00:59. After 59 more ticks it is 00:00, state=5, led[9:3]=7'h7F.
- Pause and resume: in RUN, press run at prescaler=3 and the state goes to 3 with the value frozen. Press run again and the next decrement lands 8 cycles after re-entry.
- Edges:
  - run_p in PAUSED with 00:00 goes straight to FLASH.
  - run_p coincident with the tick taking 00:01 → 00:00 ends in FLASH, not PAUSED.
- Flash and restart: in FLASH, blank toggles every 4 cycles (with the macro defined). set_p gives state=1, value 00:00, blank=0. A reset pulse mid-RUN restores all reset values on the next edge.
